// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the console receive buffer: byte width and ingress FSM encodings.
package uart_rx_fifo_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [BYTE_W-1:0] EMPTY_BYTE = 8'h00;

endpackage

// File: rtl/uart_rx_fifo_sync_pulse.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a rising-edge detector.
// The one-cycle pulse is combinational off the last stage so the consumer acts on the next edge.
module uart_rx_fifo_sync_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_pulse_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_pulse_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the RCSR/RBUF registers: handshake ingress,
// show-ahead head byte, sticky overrun, pop on a synchronized RBUF-read strobe.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BYTE_W-1:0]     i_rx_data,
  input  logic                  i_rx_ready,
  output logic                  o_rx_clear,
  input  logic                  i_pop_async,
  output logic [BYTE_W-1:0]     o_data,
  output logic                  o_ready,
  output logic                  o_overrun,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [0:0]        state_q, state_d;
  logic              rx_clear_q, rx_clear_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              ready_q, ready_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];

  logic push_req_c;
  logic pop_pulse_c;
  logic pop_eff_c;
  logic full_c;
  logic accept_c;
  logic drop_c;

  uart_rx_fifo_sync_pulse #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pop_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_async   (i_pop_async),
    .o_pulse_c (pop_pulse_c)
  );

  // Ingress handshake: one push per rx_data_ready assertion, then hold clear until it drops.
  always_comb begin
    state_d    = state_q;
    push_req_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_ready) begin
          push_req_c = 1'b1;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (!i_rx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rx_clear_d = (state_d == ST_CLEAR);
  end

  // Pop is applied before push, so a full FIFO popping in the same cycle still accepts the byte.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;

    pop_eff_c = pop_pulse_c && (count_q != '0);
    full_c    = (count_q == CNT_W'(DEPTH));
    accept_c  = push_req_c && (!full_c || pop_eff_c);
    drop_c    = push_req_c && full_c && !pop_eff_c;

    if (pop_eff_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept_c) begin
      mem_d[wr_ptr_q] = i_rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(accept_c) - CNT_W'(pop_eff_c);

    if (drop_c)         overrun_d = 1'b1;
    else if (pop_eff_c) overrun_d = 1'b0;

    ready_d = (count_d != '0);
    data_d  = ready_d ? mem_d[rd_ptr_d] : EMPTY_BYTE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rx_clear_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= EMPTY_BYTE;
    end else begin
      state_q    <= state_d;
      rx_clear_q <= rx_clear_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign o_rx_clear = rx_clear_q;
  assign o_data     = data_q;
  assign o_ready    = ready_q;
  assign o_overrun  = overrun_q;
  assign o_count    = count_q;

endmodule
